// File: rtl/dds_pkg.sv
// Shared constants for the polyphonic DDS voice bank: top-octave note increments,
// waveform codes and signed sample limits.
package dds_pkg;

   typedef enum logic [2:0] {
      WAVE_SAW      = 3'd0,
      WAVE_SQUARE   = 3'd1,
      WAVE_TRIANGLE = 3'd2,
      WAVE_SILENCE  = 3'd3
   } wave_e;

   // Phase increments for octave 10 (notes 120..131); lower octaves shift right.
   localparam logic [31:0] NOTE_TABLE [12] = '{
      32'd749115489,  32'd793660200,  32'd840853800,  32'd890853900,
      32'd943827200,  32'd999950100,  32'd1059410300, 32'd1122405600,
      32'd1189147400, 32'd1259857500, 32'd1334772900, 32'd1414142000
   };

   function automatic int sample_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sample_min(input int w);
      return -(1 << (w - 1));
   endfunction

   function automatic logic [31:0] note_increment(input logic [7:0] note);
      logic [3:0] semitone;
      logic [3:0] octave;
      semitone = 4'(note % 8'd12);
      octave   = 4'(note / 8'd12);
      if (note[7]) return '0;
      return NOTE_TABLE[semitone] >> (4'd10 - octave);
   endfunction

endpackage

// File: rtl/dds_wave_shaper.sv
// Combinational waveform former: top phase bits, waveform code and duty
// threshold in, one signed sample out.
module dds_wave_shaper
   import dds_pkg::*;
#(
   parameter int SAMPLE_W = 16
) (
   input  logic [SAMPLE_W:0]          phase_top,
   input  logic [2:0]                 form,
   input  logic [6:0]                 pulse_width,
   output logic signed [SAMPLE_W-1:0] sample
);
   localparam logic signed [SAMPLE_W-1:0] S_MAX = SAMPLE_W'(sample_max(SAMPLE_W));
   localparam logic signed [SAMPLE_W-1:0] S_MIN = SAMPLE_W'(sample_min(SAMPLE_W));

   logic [SAMPLE_W:0] tri_fold;

   always_comb begin
      // Upper half mirrors down; the exact midpoint folds to 2^SAMPLE_W and saturates.
      tri_fold = phase_top[SAMPLE_W] ? -phase_top : phase_top;
      case (form)
         WAVE_SAW:      sample = {~phase_top[SAMPLE_W], phase_top[SAMPLE_W-1 -: SAMPLE_W-1]};
         WAVE_SQUARE:   sample = (phase_top[SAMPLE_W -: 7] < pulse_width) ? S_MAX : S_MIN;
         WAVE_TRIANGLE: sample = tri_fold[SAMPLE_W] ? S_MAX
                                : {~tri_fold[SAMPLE_W-1], tri_fold[SAMPLE_W-2:0]};
         default:       sample = '0;
      endcase
   end

endmodule

// File: rtl/poly_dds_voice_bank.sv
// Time-multiplexed bank of DDS voices: one voice per cycle through a read/shape/
// accumulate pipeline, producing one mixed sample per frame.
module poly_dds_voice_bank
   import dds_pkg::*;
#(
   parameter int  NUM_VOICES = 8,
   parameter int  PHASE_W    = 32,
   parameter int  SAMPLE_W   = 16,
   localparam int VIDX_W     = $clog2(NUM_VOICES),
   localparam int OUT_W      = SAMPLE_W + VIDX_W
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    CFG_WE,
   input  logic [VIDX_W-1:0]       CFG_VOICE,
   input  logic [7:0]              NOTE,
   input  logic                    GATE,
   input  logic [2:0]              form,
   input  logic [6:0]              pulse_width,
   output logic signed [OUT_W-1:0] MIX,
   output logic                    MIX_VALID
);
   localparam logic [VIDX_W-1:0] LAST_SLOT = VIDX_W'(NUM_VOICES - 1);

   logic               gate_r  [NUM_VOICES];
   logic [2:0]         form_r  [NUM_VOICES];
   logic [6:0]         pw_r    [NUM_VOICES];
   logic [PHASE_W-1:0] inc_r   [NUM_VOICES];
   logic [PHASE_W-1:0] phase_r [NUM_VOICES];

   logic [VIDX_W-1:0]  slot;
   logic               cfg_hit;
   logic [PHASE_W-1:0] cfg_inc;

   logic               s1_valid, s1_first, s1_last, s1_gate;
   logic [2:0]         s1_form;
   logic [6:0]         s1_pw;
   logic [SAMPLE_W:0]  s1_phase_top;

   logic                       s2_valid, s2_first, s2_last;
   logic signed [SAMPLE_W-1:0] shaped, s2_sample;
   logic signed [OUT_W-1:0]    sample_ext, acc, acc_next;

   assign cfg_hit = CFG_WE && ({1'b0, CFG_VOICE} < (VIDX_W + 1)'(NUM_VOICES));
   assign cfg_inc = PHASE_W'(note_increment(NOTE));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)                  slot <= '0;
      else if (slot == LAST_SLOT) slot <= '0;
      else                        slot <= slot + VIDX_W'(1);
   end

   // A write lands after S1 has sampled the old config; a retrigger overrides the phase step.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            gate_r[v]  <= 1'b0;
            form_r[v]  <= '0;
            pw_r[v]    <= '0;
            inc_r[v]   <= '0;
            phase_r[v] <= '0;
         end
      end else begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (slot == VIDX_W'(v) && gate_r[v])
               phase_r[v] <= phase_r[v] + inc_r[v];
            if (cfg_hit && CFG_VOICE == VIDX_W'(v)) begin
               gate_r[v] <= GATE;
               form_r[v] <= form;
               pw_r[v]   <= pulse_width;
               inc_r[v]  <= cfg_inc;
               if (GATE && !gate_r[v])
                  phase_r[v] <= '0;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         s1_valid     <= 1'b0;
         s1_first     <= 1'b0;
         s1_last      <= 1'b0;
         s1_gate      <= 1'b0;
         s1_form      <= '0;
         s1_pw        <= '0;
         s1_phase_top <= '0;
      end else begin
         s1_valid     <= 1'b1;
         s1_first     <= (slot == '0);
         s1_last      <= (slot == LAST_SLOT);
         s1_gate      <= gate_r[slot];
         s1_form      <= form_r[slot];
         s1_pw        <= pw_r[slot];
         s1_phase_top <= phase_r[slot][PHASE_W-1 -: SAMPLE_W+1];
      end
   end

   dds_wave_shaper #(.SAMPLE_W(SAMPLE_W)) u_shaper (
      .phase_top   (s1_phase_top),
      .form        (s1_form),
      .pulse_width (s1_pw),
      .sample      (shaped)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         s2_valid  <= 1'b0;
         s2_first  <= 1'b0;
         s2_last   <= 1'b0;
         s2_sample <= '0;
      end else begin
         s2_valid  <= s1_valid;
         s2_first  <= s1_first;
         s2_last   <= s1_last;
         s2_sample <= s1_gate ? shaped : '0;
      end
   end

   assign sample_ext = {{VIDX_W{s2_sample[SAMPLE_W-1]}}, s2_sample};
   assign acc_next   = s2_first ? sample_ext : acc + sample_ext;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         acc       <= '0;
         MIX       <= '0;
         MIX_VALID <= 1'b0;
      end else begin
         MIX_VALID <= s2_valid && s2_last;
         if (s2_valid)
            acc <= acc_next;
         if (s2_valid && s2_last)
            MIX <= acc_next;
      end
   end

endmodule

// File: tb/tb_poly_dds_voice_bank.sv
// Bench for poly_dds_voice_bank: directed scenarios plus random config writes,
// checked against a per-voice arithmetic model of the mixed output.
module tb_poly_dds_voice_bank;
   localparam int N    = 4;
   localparam int PW   = 32;
   localparam int SW   = 16;
   localparam int VW   = 2;
   localparam int OW   = 18;
   localparam int HALF = 1 << (SW - 1);
   localparam longint PHASE_MOD = 64'd1 << PW;
   localparam longint TBL [12] = '{
      749115489,  793660200,  840853800,  890853900,
      943827200,  999950100,  1059410300, 1122405600,
      1189147400, 1259857500, 1334772900, 1414142000
   };

   logic                 CLK = 1'b0;
   logic                 RESET = 1'b0;
   logic                 CFG_WE = 1'b0;
   logic [VW-1:0]        CFG_VOICE = '0;
   logic [7:0]           NOTE = '0;
   logic                 GATE = 1'b0;
   logic [2:0]           form = '0;
   logic [6:0]           pulse_width = '0;
   logic signed [OW-1:0] MIX;
   logic                 MIX_VALID;

   int vectors = 0;
   int miscompares = 0;

   int     m_gate  [N];
   int     m_form  [N];
   int     m_pw    [N];
   longint m_inc   [N];
   longint m_phase [N];
   int     cyc;
   int     frame_sum;
   logic [OW-1:0] exp_q [$];
   logic [OW-1:0] mix_hold;

   poly_dds_voice_bank #(.NUM_VOICES(N), .PHASE_W(PW), .SAMPLE_W(SW)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .CFG_WE      (CFG_WE),
      .CFG_VOICE   (CFG_VOICE),
      .NOTE        (NOTE),
      .GATE        (GATE),
      .form        (form),
      .pulse_width (pulse_width),
      .MIX         (MIX),
      .MIX_VALID   (MIX_VALID)
   );

   always #5 CLK = ~CLK;

   function automatic longint incr_of(input int n);
      if (n > 127) return 0;
      return TBL[n % 12] >> (10 - n / 12);
   endfunction

   function automatic int sample_of(input int v);
      longint ph;
      longint t;
      longint f;
      int r;
      ph = m_phase[v];
      r = 0;
      if (m_gate[v] == 0) return 0;
      case (m_form[v])
         0: r = int'(ph >> (PW - SW)) - HALF;
         1: r = ((ph >> (PW - 7)) < longint'(m_pw[v])) ? HALF - 1 : -HALF;
         2: begin
            t = ph >> (PW - SW - 1);
            f = (t < 2 * HALF) ? t : 4 * HALF - t;
            r = int'(f) - HALF;
            if (r > HALF - 1) r = HALF - 1;
         end
         default: r = 0;
      endcase
      return r;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < N; v++) begin
         m_gate[v] = 0; m_form[v] = 0; m_pw[v] = 0; m_inc[v] = 0; m_phase[v] = 0;
      end
      cyc = 0;
      frame_sum = 0;
      exp_q.delete();
      mix_hold = '0;
   endtask

   task automatic model_edge(input int we, input int voice, input int note, input int gate,
                             input int frm, input int pw);
      int s;
      int smp;
      cyc++;
      s = (cyc - 1) % N;
      smp = sample_of(s);
      frame_sum = (s == 0) ? smp : frame_sum + smp;
      if (m_gate[s] != 0) m_phase[s] = (m_phase[s] + m_inc[s]) % PHASE_MOD;
      if (s == N - 1) exp_q.push_back(frame_sum[OW-1:0]);
      if (we != 0 && voice < N) begin
         if (gate != 0 && m_gate[voice] == 0) m_phase[voice] = 0;
         m_gate[voice] = gate;
         m_form[voice] = frm;
         m_pw[voice]   = pw;
         m_inc[voice]  = incr_of(note);
      end
   endtask

   task automatic check_outputs();
      logic exp_v;
      logic [OW-1:0] e;
      exp_v = (cyc >= N + 2) && ((cyc - 2) % N == 0);
      vectors++;
      assert (MIX_VALID === exp_v) else begin
         miscompares++;
         $error("FAIL mix_valid cyc=%0d observed=%b expected=%b", cyc, MIX_VALID, exp_v);
      end
      if (exp_v) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         mix_hold = e;
         vectors++;
         assert (MIX === e) else begin
            miscompares++;
            $error("FAIL mix cyc=%0d observed=%0d expected=%0d", cyc, MIX, $signed(e));
         end
      end else begin
         vectors++;
         assert (MIX === mix_hold) else begin
            miscompares++;
            $error("FAIL mix_hold cyc=%0d observed=%0d expected=%0d", cyc, MIX, $signed(mix_hold));
         end
      end
   endtask

   task automatic step(input int we, input int voice, input int note, input int gate,
                       input int frm, input int pw);
      CFG_WE      = (we != 0);
      CFG_VOICE   = VW'(voice);
      NOTE        = 8'(note);
      GATE        = (gate != 0);
      form        = 3'(frm);
      pulse_width = 7'(pw);
      @(posedge CLK);
      model_edge(we, voice, note, gate, frm, pw);
      @(negedge CLK);
      check_outputs();
      CFG_WE = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input int voice, input int note, input int gate, input int frm, input int pw);
      step(1, voice, note, gate, frm, pw);
   endtask

   // Advance until the slot counter holds the given value (next edge processes that voice).
   task automatic align(input int target);
      for (int g = 0; g < 2 * N && (cyc % N) != target; g++) idle(1);
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      #1;
      vectors++;
      assert (MIX === '0) else begin
         miscompares++;
         $error("FAIL reset_mix observed=%0d expected=0", MIX);
      end
      vectors++;
      assert (MIX_VALID === 1'b0) else begin
         miscompares++;
         $error("FAIL reset_valid observed=%b expected=0", MIX_VALID);
      end
      model_reset();
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
   endtask

   initial begin
      @(negedge CLK);
      do_reset();
      idle(3 * N + 4);

      // Square at full duty on voice 0, the rest gated on but silent.
      wr(0, 69, 1, 1, 127);
      for (int v = 1; v < N; v++) wr(v, 69, 1, 3, 0);
      idle(115 * N);

      do_reset();
      for (int v = 0; v < N; v++) wr(v, 60, 1, 1, 0);
      idle(4 * N);

      do_reset();
      wr(1, 69, 1, 0, 0);
      idle(20 * N);

      // Writes landing on the voice currently in S1.
      wr(2, 100, 1, 1, 64);
      idle(3 * N);
      align(2);
      wr(2, 100, 1, 0, 64);
      idle(3 * N);
      wr(3, 50, 0, 2, 0);
      idle(2 * N);
      align(3);
      wr(3, 50, 1, 2, 0);
      idle(3 * N);
      wr(1, 69, 1, 0, 0);
      idle(3 * N);

      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 3) == 0)
            wr(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 127)));
         else
            idle(1);
      end

      align(2);
      do_reset();
      idle(3 * N + 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/poly_dds_voice_bank.md
POLY_DDS_VOICE_BANK -- requirements
Module: poly_dds_voice_bank

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 8, meaning the number of voices, legal range 2..16.
REQ-002 SHALL have parameter PHASE_W, default 32, meaning the phase accumulator width, minimum 16.
REQ-003 SHALL have parameter SAMPLE_W, default 16, meaning the signed per-voice sample width, minimum 8.
REQ-004 SHALL derive localparam OUT_W = SAMPLE_W + clog2(NUM_VOICES) and localparam VIDX_W = clog2(NUM_VOICES).
REQ-005 SHALL have port CLK, input, 1 bit: the single clock.
REQ-006 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port CFG_WE, input, 1 bit: voice-configuration write strobe.
REQ-008 SHALL have port CFG_VOICE, input, VIDX_W bits: target voice index; writes with an index of NUM_VOICES or more are ignored.
REQ-009 SHALL have port NOTE, input, 8 bits: MIDI note; values 128..255 give increment 0.
REQ-010 SHALL have port GATE, input, 1 bit: voice on (1) or off (0).
REQ-011 SHALL have port form, input, 3 bits: waveform code, 0=saw, 1=square, 2=triangle, 3..7=silence.
REQ-012 SHALL have port pulse_width, input, 7 bits: square duty threshold.
REQ-013 SHALL have port MIX, output, OUT_W bits: signed sum of all voice samples for one frame.
REQ-014 SHALL have port MIX_VALID, output, 1 bit: one-cycle strobe, high when MIX updates.

Function
REQ-015 SHALL hold per-voice registers: note, gate, form, pulse_width, increment and phase (PHASE_W bits).
REQ-016 SHALL compute increment on write as NOTE_TABLE[NOTE%12] >> (10 - NOTE/12) and store it, so NOTE_TABLE covers octave 10.
REQ-017 SHALL time-multiplex voices: a slot counter runs 0..NUM_VOICES-1 and wraps, one voice per cycle, so one frame is NUM_VOICES cycles.
REQ-018 SHALL use a 3-stage pipeline: S1 reads voice state and updates phase; S2 forms the sample; S3 accumulates.
REQ-019 SHALL form each sample from the pre-update phase, then write phase += increment, mod 2^PHASE_W, only when gate=1.
REQ-020 SHALL hold phase while gate=0 and force that voice's sample to 0.
REQ-021 SHALL set the saw sample to the top SAMPLE_W phase bits with the MSB inverted, giving two's complement.
REQ-022 SHALL set the square sample to +max (2^(SAMPLE_W-1)-1) when phase[PHASE_W-1 -: 7] < pulse_width, else -max-1; pulse_width=0 gives a constant -max-1.
REQ-023 SHALL set the triangle sample to the top SAMPLE_W+1 phase bits folded at the midpoint, minus 2^(SAMPLE_W-1), saturated to the signed range.
REQ-024 SHALL make the S3 accumulator load on slot 0 and add on later slots, with no overflow possible given OUT_W.
REQ-025 SHALL copy the accumulator to MIX and pulse MIX_VALID when the last slot leaves S3; the first MIX_VALID comes NUM_VOICES+2 cycles after RESET deasserts.
REQ-026 SHALL apply CFG_WE in the cycle it is sampled; if the written voice is in S1 that same cycle, S1 uses the old config and the new one takes effect next frame.
REQ-027 SHALL reset phase to 0 on a GATE 0->1 write (retrigger); a 1->1 write SHALL keep phase.
REQ-028 SHALL apply a write while gate=0 to config only; the sample stays 0.

Reset
REQ-029 SHALL on RESET clear the slot counter, all voice registers (gate=0, phase=0, increment=0), pipeline valid bits and the accumulator, and set MIX=0 and MIX_VALID=0.
REQ-030 SHALL on RESET mid-frame drop the partial frame; no MIX_VALID SHALL be emitted for it.

Structure
REQ-031 SHALL place NOTE_TABLE (12 x 32-bit), the waveform codes and the max/min sample constants in package dds_pkg.
REQ-032 SHALL put waveform forming (phase, form, pulse_width -> sample) in one combinational sub-module, dds_wave_shaper.

Verification
REQ-033 Reset, then all gates off -> MIX=0 every frame, with MIX_VALID once per NUM_VOICES cycles starting at cycle NUM_VOICES+2.
REQ-034 NUM_VOICES=4, voice 0 square, pulse_width=127, NOTE=69, all voices retriggered -> first MIX=32767, then 32767 until phase[31:25] reaches 127.
REQ-035 All 4 voices square, pulse_width=0, gate=1 -> MIX=-131072 every frame.
REQ-036 Voice 1 saw, NOTE=69 -> phase after k frames = k*(NOTE_TABLE[9]>>5) mod 2^32, and MIX follows the saw formula exactly.
REQ-037 Write to the voice in S1 that cycle -> old sample this frame, new sample next frame; GATE 0->1 -> phase 0, 1->1 -> phase kept.
REQ-038 RESET asserted at slot 2 -> MIX=0 and MIX_VALID=0 at once; next MIX_VALID NUM_VOICES+2 cycles after release.
